scan_capture: RTL and testbench



---
 rtl/scan_capture_pkg.sv | 22 ++
 rtl/scan_capture_if.sv | 15 +
 rtl/scan_capture_classify.sv | 41 ++++
 rtl/scan_capture.sv | 149 ++++++++++++++
 tb/tb_scan_capture.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_capture_pkg.sv
// scan_capture_pkg: shared definitions for the display scan capture slice.
//   state_t   : next digit expected by the capture FSM; the encoding equals
//               the anode index, so a strobe matches when sel_idx == state.
//   AN_BLANK  : anode pattern with every strobe inactive.
//   AN_IDXk   : anode index constants for an3..an0.
package scan_capture_pkg;

  typedef enum logic [1:0] {
    EXP0 = 2'd0,
    EXP1 = 2'd1,
    EXP2 = 2'd2,
    EXP3 = 2'd3
  } state_t;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  localparam logic [1:0] AN_IDX0 = 2'd0;
  localparam logic [1:0] AN_IDX1 = 2'd1;
  localparam logic [1:0] AN_IDX2 = 2'd2;
  localparam logic [1:0] AN_IDX3 = 2'd3;

endpackage

// File: rtl/scan_capture_if.sv
// scan_capture_if: 4-digit multiplexed display scan bus.
//   an3..an0 : active-low anode strobes (all high = blank)
//   din      : 4-bit digit code, valid while exactly one anode is low
//   master   : scan driver side
//   slave    : capture/monitor side
interface scan_capture_if;
  logic       an3;
  logic       an2;
  logic       an1;
  logic       an0;
  logic [3:0] din;

  modport master (output an3, an2, an1, an0, din);
  modport slave  (input  an3, an2, an1, an0, din);
endinterface

// File: rtl/scan_capture_classify.sv
// scan_classify: classifies the sampled anode pattern {an3..an0}.
//   clkdv, reset : scan clock, asynchronous active-high reset
//   an           : anode pattern {an3,an2,an1,an0}
//   is_blank     : pattern is all-high
//   is_sel       : exactly one anode low
//   sel_idx      : index of the low anode (valid with is_sel)
//   strobe       : first cycle of a select pattern (differs from last cycle)
module scan_classify
  import scan_capture_pkg::*;
(
  input  logic       clkdv,
  input  logic       reset,
  input  logic [3:0] an,
  output logic       is_blank,
  output logic       is_sel,
  output logic [1:0] sel_idx,
  output logic       strobe
);

  logic [3:0] prev_an;

  always_ff @(posedge clkdv or posedge reset) begin
    if (reset) prev_an <= AN_BLANK;
    else       prev_an <= an;
  end

  always_comb begin
    is_blank = (an == AN_BLANK);
    is_sel   = 1'b1;
    sel_idx  = AN_IDX0;
    case (an)
      4'b0111: sel_idx = AN_IDX3;
      4'b1011: sel_idx = AN_IDX2;
      4'b1101: sel_idx = AN_IDX1;
      4'b1110: sel_idx = AN_IDX0;
      default: is_sel  = 1'b0;
    endcase
    strobe = is_sel && (an != prev_an);
  end

endmodule

// File: rtl/scan_capture.sv
// scan_capture: receiving end of the 4-digit display scan bus. Checks the
// 3->2->1->0 strobe order, rebuilds the digits and publishes whole frames.
//   clkdv, reset       : scan clock, asynchronous active-high reset
//   bus (slave)        : an3..an0 strobes and din digit code
//   digit3..digit0     : last committed frame
//   frame_valid        : one-cycle pulse on frame commit
//   seq_err            : one-cycle pulse on any protocol error
//   locked             : high from a good frame until the next error
//   frame_cnt, err_cnt : statistics, present only with CAPTURE_STATS_EN
module scan_capture
  import scan_capture_pkg::*;
#(
  parameter int unsigned BLANK_MAX = 15
`ifdef CAPTURE_STATS_EN
  , parameter int unsigned STAT_W = 8
`endif
) (
  input  logic                clkdv,
  input  logic                reset,
  scan_capture_if.slave       bus,
  output logic [3:0]          digit3,
  output logic [3:0]          digit2,
  output logic [3:0]          digit1,
  output logic [3:0]          digit0,
  output logic                frame_valid,
  output logic                seq_err,
  output logic                locked
`ifdef CAPTURE_STATS_EN
  , output logic [STAT_W-1:0] frame_cnt
  , output logic [STAT_W-1:0] err_cnt
`endif
);

  localparam int unsigned BW = $clog2(BLANK_MAX + 2);
  localparam logic [BW-1:0] BLANK_LIM = BW'(BLANK_MAX + 1);

  logic [3:0]    an;
  logic          is_blank, is_sel, strobe;
  logic [1:0]    sel_idx;
  state_t        state, state_nxt;
  logic [3:0]    sh3, sh2, sh1, sh3_nxt, sh2_nxt, sh1_nxt;
  logic [BW-1:0] blank_cnt, blank_nxt, blank_inc;
  logic          commit, err;

  always_comb an = {bus.an3, bus.an2, bus.an1, bus.an0};

  scan_classify u_classify (
    .clkdv    (clkdv),
    .reset    (reset),
    .an       (an),
    .is_blank (is_blank),
    .is_sel   (is_sel),
    .sel_idx  (sel_idx),
    .strobe   (strobe)
  );

  always_comb begin
    state_nxt = state;
    sh3_nxt   = sh3;
    sh2_nxt   = sh2;
    sh1_nxt   = sh1;
    blank_nxt = blank_cnt;
    commit    = 1'b0;
    err       = 1'b0;
    blank_inc = (blank_cnt == BLANK_LIM) ? blank_cnt : BW'(blank_cnt + 1'b1);

    if (!is_blank && !is_sel) begin
      err       = 1'b1;
      state_nxt = EXP3;
      blank_nxt = '0;
    end else if (strobe) begin
      blank_nxt = '0;
      if (state_t'(sel_idx) == state) begin
        case (state)
          EXP3:    begin sh3_nxt = bus.din; state_nxt = EXP2; end
          EXP2:    begin sh2_nxt = bus.din; state_nxt = EXP1; end
          EXP1:    begin sh1_nxt = bus.din; state_nxt = EXP0; end
          default: begin commit  = 1'b1;    state_nxt = EXP3; end
        endcase
      end else begin
        err = 1'b1;
        // An out-of-order an3 strobe is a valid frame start: resync on it.
        if (sel_idx == AN_IDX3) begin
          sh3_nxt   = bus.din;
          state_nxt = EXP2;
        end else begin
          state_nxt = EXP3;
        end
      end
    end else if (is_blank && state != EXP3) begin
      if (blank_inc == BLANK_LIM) begin
        err       = 1'b1;
        state_nxt = EXP3;
        blank_nxt = '0;
      end else begin
        blank_nxt = blank_inc;
      end
    end else if (state == EXP3) begin
      blank_nxt = '0;
    end
  end

  always_ff @(posedge clkdv or posedge reset) begin
    if (reset) begin
      state       <= EXP3;
      sh3         <= '0;
      sh2         <= '0;
      sh1         <= '0;
      blank_cnt   <= '0;
      digit3      <= '0;
      digit2      <= '0;
      digit1      <= '0;
      digit0      <= '0;
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      sh3         <= sh3_nxt;
      sh2         <= sh2_nxt;
      sh1         <= sh1_nxt;
      blank_cnt   <= blank_nxt;
      frame_valid <= commit;
      seq_err     <= err;
      if (commit) begin
        digit3 <= sh3;
        digit2 <= sh2;
        digit1 <= sh1;
        digit0 <= bus.din;
        locked <= 1'b1;
      end else if (err) begin
        locked <= 1'b0;
      end
    end
  end

`ifdef CAPTURE_STATS_EN
  always_ff @(posedge clkdv or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_valid)                frame_cnt <= frame_cnt + 1'b1;
      if (seq_err && (err_cnt != '1)) err_cnt   <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_scan_capture.sv
// tb_scan_capture: directed scan sequences for scan_capture. Expected frame
// commits and error pulses are queued with the cycle they must appear in;
// a negedge monitor pops and compares them against the DUT outputs.
// Define CAPTURE_STATS_EN to also exercise the statistics counters.
module tb_scan_capture;

  logic       clkdv = 1'b0;
  logic       reset;
  logic [3:0] digit3, digit2, digit1, digit0;
  logic       frame_valid, seq_err, locked;
`ifdef CAPTURE_STATS_EN
  logic [7:0] frame_cnt, err_cnt;
`endif

  scan_capture_if bus ();

  scan_capture #(.BLANK_MAX(15)
`ifdef CAPTURE_STATS_EN
    , .STAT_W(8)
`endif
  ) dut (
    .clkdv       (clkdv),
    .reset       (reset),
    .bus         (bus),
    .digit3      (digit3),
    .digit2      (digit2),
    .digit1      (digit1),
    .digit0      (digit0),
    .frame_valid (frame_valid),
    .seq_err     (seq_err),
    .locked      (locked)
`ifdef CAPTURE_STATS_EN
    , .frame_cnt (frame_cnt)
    , .err_cnt   (err_cnt)
`endif
  );

  always #5 clkdv = ~clkdv;

  typedef struct {
    int unsigned cyc;
    logic [15:0] dig;
  } fexp_t;

  fexp_t       fq[$];
  int unsigned eq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus; fv/er declare a frame commit / error pulse that
  // must become visible right after the edge sampling this vector.
  task automatic drv(input logic [3:0] an, input logic [3:0] d,
                     input bit fv, input bit er, input logic [15:0] exp_dig);
    fexp_t e;
    {bus.an3, bus.an2, bus.an1, bus.an0} = an;
    bus.din = d;
    if (fv) begin
      e.cyc = cyc + 1;
      e.dig = exp_dig;
      fq.push_back(e);
    end
    if (er) eq.push_back(cyc + 1);
    @(posedge clkdv);
    #1;
    cyc++;
  endtask

  task automatic blanks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drv(4'b1111, 4'h0, 1'b0, 1'b0, 16'h0);
  endtask

  // Driver-style frame: four in-order strobes separated by `gap` blanks.
  task automatic frame(input logic [15:0] d, input int unsigned gap);
    drv(4'b0111, d[15:12], 1'b0, 1'b0, 16'h0); blanks(gap);
    drv(4'b1011, d[11:8],  1'b0, 1'b0, 16'h0); blanks(gap);
    drv(4'b1101, d[7:4],   1'b0, 1'b0, 16'h0); blanks(gap);
    drv(4'b1110, d[3:0],   1'b1, 1'b0, d);     blanks(gap);
  endtask

  always @(negedge clkdv) begin
    if (!reset) begin
      if (fq.size() > 0 && fq[0].cyc <= cyc) begin
        fexp_t e;
        e = fq.pop_front();
        checks++;
        if (!frame_valid) begin
          errors++;
          $display("FAIL frame_valid: got 0 expected 1 (cycle %0d)", cyc);
        end else begin
          check("frame_digits", {digit3, digit2, digit1, digit0}, e.dig);
          check("locked_on_frame", {15'h0, locked}, 16'h1);
        end
      end else if (frame_valid) begin
        checks++;
        errors++;
        $display("FAIL frame_valid: got 1 expected 0 (cycle %0d)", cyc);
      end

      if (eq.size() > 0 && eq[0] <= cyc) begin
        void'(eq.pop_front());
        checks++;
        if (!seq_err) begin
          errors++;
          $display("FAIL seq_err: got 0 expected 1 (cycle %0d)", cyc);
        end else begin
          check("locked_on_err", {15'h0, locked}, 16'h0);
        end
      end else if (seq_err) begin
        checks++;
        errors++;
        $display("FAIL seq_err: got 1 expected 0 (cycle %0d)", cyc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    {bus.an3, bus.an2, bus.an1, bus.an0} = 4'b1111;
    bus.din = 4'h0;
    repeat (3) @(posedge clkdv);
    #1;
    check("reset_digits", {digit3, digit2, digit1, digit0}, 16'h0);
    check("reset_flags", {13'h0, frame_valid, seq_err, locked}, 16'h0);
    reset = 1'b0;
    blanks(2);
    check("idle_flags", {13'h0, frame_valid, seq_err, locked}, 16'h0);

    // Nominal scan: 16 cycles per frame.
    frame(16'h1234, 3);
    frame(16'h1234, 3);
    frame(16'h1234, 3);
    check("nominal_locked", {15'h0, locked}, 16'h1);

    // Held an1 strobe: only the first cycle's din is captured.
    drv(4'b0111, 4'h5, 1'b0, 1'b0, 16'h0); blanks(1);
    drv(4'b1011, 4'h6, 1'b0, 1'b0, 16'h0); blanks(1);
    drv(4'b1101, 4'h7, 1'b0, 1'b0, 16'h0);
    drv(4'b1101, 4'h0, 1'b0, 1'b0, 16'h0);
    drv(4'b1101, 4'hE, 1'b0, 1'b0, 16'h0); blanks(1);
    drv(4'b1110, 4'h8, 1'b1, 1'b0, 16'h5678); blanks(2);

    // Out of order 3,1,2,0: an1 errors, then 2 and 0 arrive in EXP3 and error too.
    drv(4'b0111, 4'h1, 1'b0, 1'b0, 16'h0); blanks(1);
    drv(4'b1101, 4'h3, 1'b0, 1'b1, 16'h0); blanks(1);
    drv(4'b1011, 4'h2, 1'b0, 1'b1, 16'h0); blanks(1);
    drv(4'b1110, 4'h4, 1'b0, 1'b1, 16'h0); blanks(2);
    check("ooo_digits_held", {digit3, digit2, digit1, digit0}, 16'h5678);
    check("ooo_unlocked", {15'h0, locked}, 16'h0);
    frame(16'hABCD, 1);
    check("relock", {15'h0, locked}, 16'h1);

    // Resync: stray an2, then an3 restarts the frame.
    drv(4'b1011, 4'h1, 1'b0, 1'b1, 16'h0); blanks(1);
    frame(16'h2345, 1);

    // Illegal patterns, idle and mid-frame.
    drv(4'b0011, 4'h0, 1'b0, 1'b1, 16'h0); blanks(1);
    drv(4'b0111, 4'h6, 1'b0, 1'b0, 16'h0);
    drv(4'b0101, 4'h0, 1'b0, 1'b1, 16'h0); blanks(2);
    check("illegal_unlocked", {15'h0, locked}, 16'h0);
    check("illegal_digits_held", {digit3, digit2, digit1, digit0}, 16'h2345);

    // 15 blanks inside a frame are tolerated.
    frame(16'h1234, 15);
    // The 16th blank after an3 times out; idle EXP3 then waits forever.
    drv(4'b0111, 4'h1, 1'b0, 1'b0, 16'h0);
    blanks(15);
    drv(4'b1111, 4'h0, 1'b0, 1'b1, 16'h0);
    blanks(25);
    check("timeout_unlocked", {15'h0, locked}, 16'h0);
    frame(16'h4321, 0);

    // Reset mid-frame discards the partial frame and clears outputs.
    drv(4'b0111, 4'h1, 1'b0, 1'b0, 16'h0); blanks(1);
    drv(4'b1011, 4'h2, 1'b0, 1'b0, 16'h0);
    reset = 1'b1;
    #2;
    check("midreset_digits", {digit3, digit2, digit1, digit0}, 16'h0);
    check("midreset_flags", {13'h0, frame_valid, seq_err, locked}, 16'h0);
    @(posedge clkdv);
    #1;
    cyc++;
    reset = 1'b0;
    blanks(1);
    drv(4'b1101, 4'h3, 1'b0, 1'b1, 16'h0); blanks(1);
    drv(4'b1110, 4'h4, 1'b0, 1'b1, 16'h0); blanks(1);
    frame(16'h9876, 2);

`ifdef CAPTURE_STATS_EN
    reset = 1'b1;
    @(posedge clkdv);
    #1;
    cyc++;
    reset = 1'b0;
    for (int i = 0; i < 300; i++) frame(16'h1234, 0);
    for (int i = 0; i < 300; i++) drv(4'b0011, 4'h0, 1'b0, 1'b1, 16'h0);
    blanks(3);
    check("frame_cnt", {8'h0, frame_cnt}, 16'd44);
    check("err_cnt", {8'h0, err_cnt}, 16'd255);
`endif

    blanks(4);
    checks++;
    if (fq.size() != 0 || eq.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d/%0d expected 0/0", fq.size(), eq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
